// File: rtl/vec_packet_router_pkg.sv
// vec_packet_pkg: shared packet type, counter width and destination decode
// for the vector packet router.
package vec_packet_pkg;

  localparam int PKT_HDR_W  = 16;
  localparam int PKT_ADDR_W = 16;
  localparam int PKT_DATA_W = 32;
  localparam int DROP_CNT_W = 16;

  typedef struct packed {
    logic [PKT_HDR_W-1:0]  header;
    logic [PKT_ADDR_W-1:0] addr;
    logic [PKT_DATA_W-1:0] data;
  } packet_t;

  // Destination port is the low destW bits of the address.
  function automatic int unsigned dest_idx(input logic [31:0] addr, input int unsigned destW);
    return addr & ((32'd1 << destW) - 32'd1);
  endfunction

endpackage

// File: rtl/vec_packet_router_fifo.sv
// vec_packet_fifo: single-clock FIFO of packets, DEPTH entries (power of two).
// Count is one bit wider than the pointers so full and empty are distinct.
module vec_packet_fifo
  import vec_packet_pkg::*;
#(
  parameter type ELEM_T = packet_t,
  parameter int  DEPTH  = 4
) (
  input  logic  clock,
  input  logic  reset_n,
  input  logic  push,
  input  logic  pop,
  input  ELEM_T wrData,
  output logic  full,
  output logic  empty,
  output ELEM_T head
);

  localparam int AW = $clog2(DEPTH);

  ELEM_T         mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic          doPush;
  logic          doPop;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign head   = mem[rdPtr];

  // Storage needs no reset: empty gates visibility of stale entries.
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

  // Pointers wrap naturally; count tracks occupancy.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vec_packet_router.sv
// vec_packet_router: routes {header,addr,data} packets from N_IN valid/ready
// inputs to N_OUT per-port FIFOs, round-robin arbitration per output.
// Packets whose destination index is >= N_OUT are accepted and dropped.
// Optional: VEC_PACKET_ROUTER_STATS_EN adds io_pkt_count, one 32-bit
// wrapping pop counter per output.
module vec_packet_router
  import vec_packet_pkg::*;
#(
  parameter int N_IN       = 3,
  parameter int N_OUT      = 4,
  parameter int HDR_W      = 16,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [N_IN-1:0]         io_inPacket_tx_valid,
  output logic [N_IN-1:0]         io_inPacket_tx_ready,
  input  logic [N_IN*HDR_W-1:0]   io_inPacket_tx_header,
  input  logic [N_IN*ADDR_W-1:0]  io_inPacket_tx_addr,
  input  logic [N_IN*DATA_W-1:0]  io_inPacket_tx_data,
  output logic [N_OUT-1:0]        io_outPacket_rx_valid,
  input  logic [N_OUT-1:0]        io_outPacket_rx_ready,
  output logic [N_OUT*HDR_W-1:0]  io_outPacket_rx_header,
  output logic [N_OUT*ADDR_W-1:0] io_outPacket_rx_addr,
  output logic [N_OUT*DATA_W-1:0] io_outPacket_rx_data,
  output logic [DROP_CNT_W-1:0]   io_drop_count
`ifdef VEC_PACKET_ROUTER_STATS_EN
  , output logic [N_OUT*32-1:0]   io_pkt_count
`endif
);

  localparam int DEST_W = $clog2(N_OUT);
  localparam int PTR_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [DEST_W:0] NOUT_V = (DEST_W+1)'(N_OUT);

  typedef struct packed {
    logic [HDR_W-1:0]  header;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pkt_t;

  pkt_t                         inPkt [N_IN];
  logic [DEST_W-1:0]            dest [N_IN];
  logic [N_IN-1:0]              destBad;
  logic [N_OUT-1:0][N_IN-1:0]   grant;
  logic [N_OUT-1:0][PTR_W-1:0]  rrPtr;
  logic [N_OUT-1:0][PTR_W-1:0]  rrNext;
  pkt_t                         wrPkt [N_OUT];
  pkt_t                         fifoHead [N_OUT];
  logic [N_OUT-1:0]             pushEn;
  logic [N_OUT-1:0]             popEn;
  logic [N_OUT-1:0]             fifoFull;
  logic [N_OUT-1:0]             fifoEmpty;
  logic [DROP_CNT_W-1:0]        dropCnt;
  logic [31:0]                  dropSum;

  // Unpack input channels and decode destinations.
  for (genvar i = 0; i < N_IN; i++) begin : gIn
    assign inPkt[i] = '{header: io_inPacket_tx_header[i*HDR_W +: HDR_W],
                        addr:   io_inPacket_tx_addr[i*ADDR_W +: ADDR_W],
                        data:   io_inPacket_tx_data[i*DATA_W +: DATA_W]};
    assign dest[i]    = DEST_W'(dest_idx(32'(inPkt[i].addr), DEST_W));
    assign destBad[i] = ({1'b0, dest[i]} >= NOUT_V);
  end

  // Per-output round-robin: first requester at or after rrPtr wins and
  // steers the crossbar; the pointer moves past the winner on any grant.
  always_comb begin : pArb
    int   idx;
    logic hit;
    grant  = '0;
    pushEn = '0;
    rrNext = rrPtr;
    idx    = 0;
    hit    = 1'b0;
    for (int o = 0; o < N_OUT; o++) begin
      wrPkt[o] = '0;
      hit      = 1'b0;
      for (int k = 0; k < N_IN; k++) begin
        idx = int'(rrPtr[o]) + k;
        if (idx >= N_IN) idx = idx - N_IN;
        if (!hit && io_inPacket_tx_valid[idx] && !destBad[idx] && int'(dest[idx]) == o) begin
          hit            = 1'b1;
          grant[o][idx]  = 1'b1;
          wrPkt[o]       = inPkt[idx];
          rrNext[o]      = (idx == N_IN - 1) ? '0 : PTR_W'(idx + 1);
        end
      end
      pushEn[o] = hit & ~fifoFull[o];
    end
  end

  // Ready uses registered full only, so a same-cycle pop never frees a slot.
  always_comb begin : pReady
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      ok = 1'b0;
      for (int o = 0; o < N_OUT; o++)
        if (grant[o][i] && !fifoFull[o]) ok = 1'b1;
      io_inPacket_tx_ready[i] = reset_n & (destBad[i] | ok);
    end
  end

  // Arbiter pointers.
  always_ff @(posedge clock) begin
    if (!reset_n) rrPtr <= '0;
    else          rrPtr <= rrNext;
  end

  // Sum of invalid packets taken this cycle, added to the running count.
  always_comb begin
    dropSum = 32'(dropCnt);
    for (int i = 0; i < N_IN; i++)
      dropSum = dropSum + 32'(io_inPacket_tx_valid[i] & destBad[i]);
  end

  // Saturating drop counter.
  always_ff @(posedge clock) begin
    if (!reset_n)                                   dropCnt <= '0;
    else if (dropSum > 32'((1 << DROP_CNT_W) - 1))  dropCnt <= '1;
    else                                            dropCnt <= dropSum[DROP_CNT_W-1:0];
  end

  assign io_drop_count = dropCnt;

  // One FIFO per output; head drives the output fields directly.
  for (genvar o = 0; o < N_OUT; o++) begin : gOut
    vec_packet_fifo #(
      .ELEM_T (pkt_t),
      .DEPTH  (FIFO_DEPTH)
    ) uFifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (pushEn[o]),
      .pop     (popEn[o]),
      .wrData  (wrPkt[o]),
      .full    (fifoFull[o]),
      .empty   (fifoEmpty[o]),
      .head    (fifoHead[o])
    );
    assign popEn[o] = ~fifoEmpty[o] & io_outPacket_rx_ready[o];
    assign io_outPacket_rx_header[o*HDR_W +: HDR_W]  = fifoHead[o].header;
    assign io_outPacket_rx_addr[o*ADDR_W +: ADDR_W]  = fifoHead[o].addr;
    assign io_outPacket_rx_data[o*DATA_W +: DATA_W]  = fifoHead[o].data;
  end

  assign io_outPacket_rx_valid = ~fifoEmpty;

`ifdef VEC_PACKET_ROUTER_STATS_EN
  logic [N_OUT-1:0][31:0] pktCnt;

  // Per-output pop counters, wrapping.
  always_ff @(posedge clock) begin
    if (!reset_n) pktCnt <= '0;
    else
      for (int o = 0; o < N_OUT; o++)
        if (popEn[o]) pktCnt[o] <= pktCnt[o] + 32'd1;
  end

  assign io_pkt_count = pktCnt;
`endif

endmodule

// File: tb/tb_vec_packet_router.sv
// tb_vec_packet_router: directed + randomized checks of vec_packet_router
// against a queue-based reference model; second instance with N_OUT=3
// exercises the drop path and drop counter saturation.
module tb_vec_packet_router;

  localparam int NI    = 3;
  localparam int NO    = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] a;
    logic [31:0] d;
  } pkt_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset_n;
  logic [2:0]   txValid, txReady;
  logic [47:0]  txHdr, txAddr;
  logic [95:0]  txData;
  logic [3:0]   rxValid, rxReady;
  logic [63:0]  rxHdr, rxAddr;
  logic [127:0] rxData;
  logic [15:0]  dropCnt;

  logic         dRst_n;
  logic [2:0]   dValid, dReady;
  logic [47:0]  dHdr, dAddr;
  logic [95:0]  dData;
  logic [2:0]   dRxValid, dRxReady;
  logic [47:0]  dRxHdr, dRxAddr;
  logic [95:0]  dRxData;
  logic [15:0]  dDrop;

`ifdef VEC_PACKET_ROUTER_STATS_EN
  logic [127:0] pktCount;
  logic [95:0]  dPktCount;
`endif

  vec_packet_router #(.N_IN(NI), .N_OUT(NO), .FIFO_DEPTH(DEPTH)) uDut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .io_inPacket_tx_valid   (txValid),
    .io_inPacket_tx_ready   (txReady),
    .io_inPacket_tx_header  (txHdr),
    .io_inPacket_tx_addr    (txAddr),
    .io_inPacket_tx_data    (txData),
    .io_outPacket_rx_valid  (rxValid),
    .io_outPacket_rx_ready  (rxReady),
    .io_outPacket_rx_header (rxHdr),
    .io_outPacket_rx_addr   (rxAddr),
    .io_outPacket_rx_data   (rxData),
    .io_drop_count          (dropCnt)
`ifdef VEC_PACKET_ROUTER_STATS_EN
    , .io_pkt_count         (pktCount)
`endif
  );

  vec_packet_router #(.N_IN(3), .N_OUT(3), .FIFO_DEPTH(4)) uDrop (
    .clock                  (clock),
    .reset_n                (dRst_n),
    .io_inPacket_tx_valid   (dValid),
    .io_inPacket_tx_ready   (dReady),
    .io_inPacket_tx_header  (dHdr),
    .io_inPacket_tx_addr    (dAddr),
    .io_inPacket_tx_data    (dData),
    .io_outPacket_rx_valid  (dRxValid),
    .io_outPacket_rx_ready  (dRxReady),
    .io_outPacket_rx_header (dRxHdr),
    .io_outPacket_rx_addr   (dRxAddr),
    .io_outPacket_rx_data   (dRxData),
    .io_drop_count          (dDrop)
`ifdef VEC_PACKET_ROUTER_STATS_EN
    , .io_pkt_count         (dPktCount)
`endif
  );

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  pkt_t        cur [NI];
  pkt_t        q [NO][$];
  int          ptr [NO];
  int          mPop [NO];
  logic [15:0] mDrop;
  logic [2:0]  modelRdy, obsRdy;
  logic [3:0]  obsValid;
  logic [63:0] obsHead [NO];

  task automatic newPkt(input int i, input logic [15:0] addr);
    cur[i] = '{h: 16'($urandom), a: addr, d: $urandom};
  endtask

  // One clock: drive, compare at negedge, advance model to post-edge state.
  task automatic step();
    int         win [NO];
    logic [2:0] expRdy;
    logic [3:0] expValid;
    for (int i = 0; i < NI; i++) begin
      txHdr[i*16 +: 16]  = cur[i].h;
      txAddr[i*16 +: 16] = cur[i].a;
      txData[i*32 +: 32] = cur[i].d;
    end
    @(negedge clock);
    expRdy   = '0;
    expValid = '0;
    for (int o = 0; o < NO; o++) begin
      win[o] = -1;
      for (int k = 0; k < NI; k++) begin
        int i;
        i = (ptr[o] + k) % NI;
        if (win[o] < 0 && txValid[i] && int'(cur[i].a % 16'd4) == o) win[o] = i;
      end
      if (reset_n && win[o] >= 0 && q[o].size() < DEPTH) expRdy[win[o]] = 1'b1;
      expValid[o] = (q[o].size() > 0);
    end
    obsRdy   = txReady;
    obsValid = rxValid;
    chk("txReady", 64'(txReady), 64'(expRdy));
    chk("rxValid", 64'(rxValid), 64'(expValid));
    chk("dropCnt", 64'(dropCnt), 64'(mDrop));
    for (int o = 0; o < NO; o++) begin
      obsHead[o] = {rxHdr[o*16 +: 16], rxAddr[o*16 +: 16], rxData[o*32 +: 32]};
      if (q[o].size() > 0) chk("rxHead", obsHead[o], q[o][0]);
`ifdef VEC_PACKET_ROUTER_STATS_EN
      chk("pktCount", 64'(pktCount[o*32 +: 32]), 64'(mPop[o]));
`endif
    end
    if (!reset_n) begin
      for (int o = 0; o < NO; o++) begin
        q[o].delete();
        ptr[o]  = 0;
        mPop[o] = 0;
      end
      mDrop = '0;
    end else begin
      for (int o = 0; o < NO; o++) begin
        if (q[o].size() > 0 && rxReady[o]) begin
          void'(q[o].pop_front());
          mPop[o]++;
        end
        if (win[o] >= 0) begin
          if (expRdy[win[o]]) q[o].push_back(cur[win[o]]);
          ptr[o] = (win[o] + 1) % NI;
        end
      end
    end
    modelRdy = expRdy;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int acc;
    int sent;
    reset_n  = 1'b0;
    txValid  = 3'b111;
    rxReady  = '0;
    modelRdy = '0;
    mDrop    = '0;
    dRst_n   = 1'b0;
    dValid   = '0;
    dRxReady = '1;
    dHdr     = '0;
    dAddr    = '0;
    dData    = '0;
    for (int i = 0; i < NI; i++) newPkt(i, 16'($urandom));
    for (int o = 0; o < NO; o++) begin ptr[o] = 0; mPop[o] = 0; end
    @(posedge clock);
    #1;

    // Reset with all inputs valid
    repeat (3) step();
    chk("rstReady", 64'(obsRdy), 64'd0);
    chk("rstValid", 64'(obsValid), 64'd0);
    chk("rstDrop", 64'(dropCnt), 64'd0);
    reset_n = 1'b1;
    txValid = '0;

    // Single packet to out2
    cur[0]  = '{h: 16'hA5A5, a: 16'h0002, d: 32'hDEADBEEF};
    txValid = 3'b001;
    step();
    chk("singleRdy", 64'(obsRdy), 64'h1);
    txValid = '0;
    step();
    chk("singleValid", 64'(obsValid), 64'h4);
    chk("singleHead", obsHead[2], 64'hA5A5_0002_DEADBEEF);
    rxReady = '1;
    repeat (2) step();

    // Contention on out1 after a fresh reset: grants rotate 0,1,2,...
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    rxReady = 4'b0010;
    for (int i = 0; i < NI; i++) newPkt(i, 16'h0001);
    txValid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("rrGrant", 64'(obsRdy), 64'(1 << (c % 3)));
      for (int i = 0; i < NI; i++)
        if (modelRdy[i]) newPkt(i, 16'h0001 + 16'(c * 16));
    end
    txValid = '0;
    rxReady = '1;
    repeat (3) step();

    // Backpressure on out3: four fit, fifth waits for a pop
    rxReady = 4'b0111;
    txValid = 3'b010;
    newPkt(1, 16'h0003);
    acc  = 0;
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (obsRdy[1]) acc++;
      if (modelRdy[1]) begin
        sent++;
        if (sent < 5) newPkt(1, 16'(sent * 4 + 3));
        else txValid[1] = 1'b0;
      end
    end
    chk("bpAccepted", 64'(acc), 64'd4);
    chk("bpStall", 64'(obsRdy[1]), 64'd0);
    rxReady[3] = 1'b1;
    step();
    chk("bpFullHold", 64'(obsRdy[1]), 64'd0);
    step();
    chk("bpAfterPop", 64'(obsRdy[1]), 64'd1);
    txValid = '0;
    repeat (6) step();

    // Randomized traffic with a mid-run reset
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) reset_n = 1'b0;
      if (c == 2002) reset_n = 1'b1;
      rxReady = 4'($urandom);
      for (int i = 0; i < NI; i++)
        if (!txValid[i] || modelRdy[i]) begin
          txValid[i] = ($urandom_range(0, 9) < 6);
          newPkt(i, 16'($urandom));
        end
      step();
    end
    txValid = '0;
    rxReady = '1;
    repeat (6) step();

    // Drop path on the N_OUT=3 instance
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    chk("d3RstDrop", 64'(dDrop), 64'd0);
    @(posedge clock); #1;
    dRst_n = 1'b1;
    dAddr  = {16'h000B, 16'h0007, 16'h0003};
    dValid = 3'b001;
    @(negedge clock);
    chk("dropReady", 64'(dReady[0]), 64'd1);
    @(posedge clock); #1;
    dValid = '0;
    @(negedge clock);
    chk("dropNoOut", 64'(dRxValid), 64'd0);
    chk("dropOne", 64'(dDrop), 64'd1);
    @(posedge clock); #1;
    dAddr[15:0]  = 16'h0006;
    dData[31:0]  = 32'h1234_5678;
    dValid       = 3'b001;
    @(negedge clock);
    chk("d3Ready", 64'(dReady[0]), 64'd1);
    @(posedge clock); #1;
    dValid = '0;
    @(negedge clock);
    chk("d3Route", 64'(dRxValid), 64'h4);
    chk("d3Data", 64'(dRxData[95:64]), 64'h1234_5678);
    chk("d3DropKeep", 64'(dDrop), 64'd1);
    @(posedge clock); #1;
    dAddr  = {16'h000B, 16'h0007, 16'h0003};
    dValid = 3'b111;
    repeat (100) @(posedge clock);
    #1;
    @(negedge clock);
    chk("dropMid", 64'(dDrop), 64'd301);
    repeat (21845) @(posedge clock);
    #1;
    @(negedge clock);
    chk("dropSat", 64'(dDrop), 64'hFFFF);
    repeat (10) @(posedge clock);
    #1;
    @(negedge clock);
    chk("dropSatHold", 64'(dDrop), 64'hFFFF);
    @(posedge clock); #1;
    dValid = '0;
    dRst_n = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("dropRst", 64'(dDrop), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
